// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Purpose  : PC sequencer for a 32-word async instruction ROM with a one-entry
//            fetch buffer, redirect flush, address-fault halt and debug step.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 19
) (
    input  logic        clk,
    input  logic        rst,
    output logic [4:0]  rom_addr,
    input  logic [31:0] rom_inst,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        step,
    output logic        addr_err,
    output logic        halted,
    output logic [31:0] fetch_cnt
);

    localparam logic [5:0] c_ROM_DEPTH = 6'(ROM_DEPTH);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    logic        r_addr_err;
    logic [31:0] r_fetch_cnt;

    logic        w_fault;
    logic        w_buf_free;
    logic        w_xfer;
    logic        w_load;
    logic        w_fault_pulse;

    assign w_fault    = (r_pc[1:0] != 2'b00) || (r_pc[31:7] != 25'd0) ||
                        ({1'b0, r_pc[6:2]} >= c_ROM_DEPTH);
    assign w_buf_free = !r_if_valid || id_ready;
    assign w_xfer     = r_if_valid && id_ready;

    // A redirect outranks the fault check on the old PC; the new target is
    // checked on the following cycle. A fault halt stays put until redirected.
    always_comb begin
        w_state_next  = r_state;
        w_load        = 1'b0;
        w_fault_pulse = 1'b0;
        if (redirect_valid) begin
            w_state_next = halt_req ? S_HALT : S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_fault) begin
                        w_fault_pulse = 1'b1;
                        w_state_next  = S_HALT;
                    end else if (halt_req) begin
                        w_state_next = S_HALT;
                    end else begin
                        w_load = w_buf_free;
                    end
                end
                S_HALT: begin
                    if (w_fault) begin
                        w_state_next = S_HALT;
                    end else if (!halt_req) begin
                        w_state_next = S_FETCH;
                    end else if (step) begin
                        w_load = w_buf_free;
                    end
                end
                default: w_state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_if_pc     <= 32'd0;
            r_if_inst   <= 32'd0;
            r_addr_err  <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_addr_err <= w_fault_pulse;
            if (w_xfer) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                r_pc       <= redirect_pc;
                r_if_valid <= 1'b0;
            end else if (w_load) begin
                r_if_pc    <= r_pc;
                r_if_inst  <= rom_inst;
                r_if_valid <= 1'b1;
                r_pc       <= r_pc + 32'd4;
            end else if (w_xfer) begin
                r_if_valid <= 1'b0;
            end
        end
    end

    assign rom_addr  = r_pc[6:2];
    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;
    assign addr_err  = r_addr_err;
    assign halted    = (r_state == S_HALT);
    assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Purpose  : Scoreboard bench for inst_fetch_ctrl with a behavioural ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        step;
    logic        addr_err;
    logic        halted;
    logic [31:0] fetch_cnt;

    logic [31:0] rom [32];
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    assign rom_inst = rom[rom_addr];

    always #5 clk = ~clk;

    inst_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .ROM_DEPTH (19)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .step           (step),
        .addr_err       (addr_err),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, rom[pc[6:2]]});
    endtask

    task automatic push_range(input logic [31:0] first, input logic [31:0] last);
        for (logic [31:0] a = first; a <= last; a += 32'd4) push_exp(a);
    endtask

    // Monitor: every accepted buffer must match the next expected fetch.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst === 1'b0 && if_valid === 1'b1 && id_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_xfer: got pc %h, none expected", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_pc", if_pc, e[63:32]);
                chk("xfer_inst", if_inst, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0101;
        rom[0] = 32'h0000_0000;
        rom[4] = 32'h2401_0000;
        rom[5] = 32'h2402_0000;
        rom[6] = 32'h2003_0000;
        rom[9] = 32'h0004_2000;

        rst = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        halt_req = 1'b0; step = 1'b0;
        tick(); tick();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);

        // Streaming with decode always ready
        rst = 1'b0;
        push_range(32'h00, 32'h10);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("stream_valid", 32'(if_valid), 32'd1);
            chk("stream_pc", if_pc, 32'(4 * (k - 1)));
            chk("stream_cnt", fetch_cnt, 32'(k - 1));
            if (k == 5) chk("stream_inst10", if_inst, 32'h2401_0000);
        end

        // Backpressure on 0x14
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_pc", if_pc, 32'h14);
            chk("stall_inst", if_inst, 32'h2402_0000);
            chk("stall_rom_addr", 32'(rom_addr), 32'd6);
            chk("stall_cnt", fetch_cnt, 32'd5);
        end
        id_ready = 1'b1;
        push_range(32'h14, 32'h40);
        tick();
        chk("release_pc", if_pc, 32'h18);
        chk("release_inst", if_inst, 32'h2003_0000);
        repeat (10) tick();
        chk("pre_redirect_pc", if_pc, 32'h40);

        // Redirect while 0x40 is accepted
        redirect_valid = 1'b1; redirect_pc = 32'h24;
        tick();
        redirect_valid = 1'b0;
        chk("flush_valid", 32'(if_valid), 32'd0);
        chk("flush_cnt", fetch_cnt, 32'd17);
        push_range(32'h24, 32'h48);
        tick();
        chk("target_pc", if_pc, 32'h24);
        chk("target_inst", if_inst, 32'h0004_2000);
        repeat (9) tick();
        chk("last_pc", if_pc, 32'h48);

        // Sequential run past the populated ROM
        tick();
        chk("seqflt_addr_err", 32'(addr_err), 32'd1);
        chk("seqflt_halted", 32'(halted), 32'd1);
        chk("seqflt_valid", 32'(if_valid), 32'd0);
        chk("seqflt_cnt", fetch_cnt, 32'd27);
        chk("seqflt_rom_addr", 32'(rom_addr), 32'd19);
        tick();
        chk("seqflt_pulse_end", 32'(addr_err), 32'd0);
        chk("seqflt_sticky", 32'(halted), 32'd1);
        tick();
        chk("seqflt_no_load", 32'(if_valid), 32'd0);

        // Recover via redirect, then redirect to a misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        chk("recover_halted", 32'(halted), 32'd0);
        chk("recover_addr_err", 32'(addr_err), 32'd0);
        redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        chk("misalign_no_err_yet", 32'(addr_err), 32'd0);
        chk("misalign_rom_addr", 32'(rom_addr), 32'd8);
        tick();
        chk("misalign_addr_err", 32'(addr_err), 32'd1);
        chk("misalign_halted", 32'(halted), 32'd1);
        tick();
        chk("misalign_pulse_end", 32'(addr_err), 32'd0);
        chk("misalign_no_load", 32'(if_valid), 32'd0);

        // Debug halt and single step
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("dbg_resume_halted", 32'(halted), 32'd0);
        push_range(32'h00, 32'h10);
        repeat (5) tick();
        chk("dbg_pc10", if_pc, 32'h10);
        halt_req = 1'b1;
        tick();
        chk("dbg_halted", 32'(halted), 32'd1);
        chk("dbg_drained", 32'(if_valid), 32'd0);
        chk("dbg_cnt", fetch_cnt, 32'd32);
        repeat (2) begin
            tick();
            chk("dbg_no_load", 32'(if_valid), 32'd0);
        end
        for (int s = 0; s < 3; s++) begin
            push_exp(32'h14 + 32'(4 * s));
            step = 1'b1;
            tick();
            step = 1'b0;
            chk("step_valid", 32'(if_valid), 32'd1);
            chk("step_pc", if_pc, 32'h14 + 32'(4 * s));
            tick();
            chk("step_single", 32'(if_valid), 32'd0);
        end
        halt_req = 1'b0;
        tick();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_gap", 32'(if_valid), 32'd0);
        tick();
        id_ready = 1'b0;
        chk("resume_pc", if_pc, 32'h20);
        chk("resume_inst", if_inst, rom[8]);
        chk("resume_cnt", fetch_cnt, 32'd35);

        // Reset during a stall
        tick();
        chk("midstall_hold", if_pc, 32'h20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 32'(if_valid), 32'd0);
        chk("mrst_pc", if_pc, 32'd0);
        chk("mrst_inst", if_inst, 32'd0);
        chk("mrst_cnt", fetch_cnt, 32'd0);
        chk("mrst_halted", 32'(halted), 32'd0);
        tick();
        chk("mrst_refetch_valid", 32'(if_valid), 32'd1);
        chk("mrst_refetch_pc", if_pc, 32'h0);
        chk("mrst_rom_addr", 32'(rom_addr), 32'd1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
